// File: rtl/wired_slot_alloc_pkg.sv
// Shared types for consumers of the free-slot allocator.
package wired_slot_alloc_pkg;

  localparam int unsigned SLOTS_DEF = 16;
  localparam int unsigned IDX_W_DEF = $clog2(SLOTS_DEF);

  typedef logic [IDX_W_DEF-1:0] slot_idx_t;

  typedef enum logic {
    LZ_LOW  = 1'b0,
    LZ_HIGH = 1'b1
  } lz_mode_e;

endpackage

// File: rtl/wired_count_leading.sv
// Priority finder: MODE=0 returns the lowest set bit, MODE=1 the highest.
module wired_count_leading #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MODE  = 0
) (
  input  logic [WIDTH-1:0]         in,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     empty
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  // Last write wins, so scan order picks which end has priority.
  always_comb begin
    idx = '0;
    if (MODE == 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (in[i]) idx = IDX_W'(i);
      end
    end
  end

  assign empty = ~|in;

endmodule

// File: rtl/wired_slot_alloc.sv
// Free-slot allocator: offers the lowest free index each cycle over valid/ready,
// accepts returns on the free port and restores every slot on flush.
module wired_slot_alloc
  import wired_slot_alloc_pkg::*;
#(
  parameter int unsigned SLOTS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       alloc_valid_o,
  input  logic                       alloc_ready_i,
  output logic [$clog2(SLOTS)-1:0]   alloc_idx_o,
  input  logic                       free_valid_i,
  input  logic [$clog2(SLOTS)-1:0]   free_idx_i,
  input  logic                       flush_i,
  output logic [$clog2(SLOTS+1)-1:0] avail_cnt_o,
  output logic                       err_o
);

  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);

  logic [SLOTS-1:0] free_q;
  logic [SLOTS-1:0] free_d;
  logic [IDX_W-1:0] lz_idx;
  logic             lz_empty;
  logic             take;
  logic             load;
  logic             in_range;
  logic             already_free;
  logic             legal_free;
  logic             bad_free;

  wired_count_leading #(
    .WIDTH (SLOTS),
    .MODE  (0)
  ) u_lz (
    .in    (free_q),
    .idx   (lz_idx),
    .empty (lz_empty)
  );

  // A power-of-two slot count cannot be addressed out of range.
  generate
    if ((1 << IDX_W) == SLOTS) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = ({1'b0, free_idx_i} < (IDX_W + 1)'(SLOTS));
    end
  endgenerate

  assign take = alloc_valid_o & alloc_ready_i;
  assign load = (~alloc_valid_o | alloc_ready_i) & ~lz_empty & ~flush_i;

  // The held offer counts as allocated-but-not-owned, so returning it is an error.
  assign already_free = in_range &
                        (free_q[free_idx_i] | (alloc_valid_o & (alloc_idx_o == free_idx_i)));
  assign legal_free   = free_valid_i & ~flush_i & in_range & ~already_free;
  assign bad_free     = free_valid_i & ~flush_i & (~in_range | already_free);

  // Load and a legal free always touch different bits; flush overrides both.
  always_comb begin
    free_d = free_q;
    if (load)       free_d[lz_idx]     = 1'b0;
    if (legal_free) free_d[free_idx_i] = 1'b1;
    if (flush_i)    free_d             = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q        <= '1;
      alloc_valid_o <= 1'b0;
      alloc_idx_o   <= '0;
      avail_cnt_o   <= CNT_W'(SLOTS);
      err_o         <= 1'b0;
    end else begin
      free_q <= free_d;
      if (bad_free) err_o <= 1'b1;
      if (flush_i) begin
        alloc_valid_o <= 1'b0;
        avail_cnt_o   <= CNT_W'(SLOTS);
      end else begin
        if (load) begin
          alloc_valid_o <= 1'b1;
          alloc_idx_o   <= lz_idx;
        end else if (take) begin
          alloc_valid_o <= 1'b0;
        end
        if (legal_free & ~take)      avail_cnt_o <= avail_cnt_o + CNT_W'(1);
        else if (take & ~legal_free) avail_cnt_o <= avail_cnt_o - CNT_W'(1);
      end
    end
  end

endmodule
